traffic_light_controller: RTL and testbench
===========================================

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter T_MAIN, default 7, SHALL set the cycle count of state S1 (both main roads green).
REQ-002 Parameter T_TURN, default 5, SHALL set the cycle count of state S3 (M1 and MT green).
REQ-003 Parameter T_SIDE, default 3, SHALL set the cycle count of state S5 (side road green).
REQ-004 Parameter T_YEL, default 2, SHALL set the cycle count of every yellow state (S2, S4, S6).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port light_M1, output, 3 bits: main road 1 lamp, one-hot {red, yellow, green}.
REQ-008 Port light_S, output, 3 bits: side road lamp, same encoding.
REQ-009 Port light_MT, output, 3 bits: main-road turn lamp, same encoding.
REQ-010 Port light_M2, output, 3 bits: main road 2 lamp, same encoding.
REQ-011 Lamp encoding SHALL be: 3'b001 green, 3'b010 yellow, 3'b100 red; no other value SHALL be driven.

Function
REQ-012 A Moore FSM SHALL hold six states S1..S6, each paired with one output table row:
REQ-013 S1: M1 G, M2 G, MT R, S R; lasts T_MAIN cycles; next S2.
REQ-014 S2: M1 G, M2 Y, MT R, S R; lasts T_YEL cycles; next S3.
REQ-015 S3: M1 G, M2 R, MT G, S R; lasts T_TURN cycles; next S4.
REQ-016 S4: M1 Y, M2 R, MT Y, S R; lasts T_YEL cycles; next S5.
REQ-017 S5: M1 R, M2 R, MT R, S G; lasts T_SIDE cycles; next S6.
REQ-018 S6: M1 R, M2 R, MT R, S Y; lasts T_YEL cycles; next S1 (wrap).
REQ-019 A dwell counter SHALL increment every cycle; when it equals (state duration - 1) the state SHALL advance and the counter SHALL clear to 0 on the same edge.
REQ-020 Outputs SHALL be decoded combinationally from the current state only (no extra latency).
REQ-021 Default full cycle SHALL be 21 clocks (7+2+5+2+3+2).
REQ-022 At no time SHALL any two conflicting directions (S green/yellow with any main lamp non-red; MT non-red with M2 non-red) be simultaneously non-red.
REQ-023 Unreachable state encodings SHALL recover to S1 with counter 0 on the next edge.
REQ-024 Counter width SHALL accommodate the largest parameter; all durations SHALL be >= 1.

Reset
REQ-025 While rst=1 the FSM SHALL be in S1 and the counter 0, immediately (asynchronously) regardless of clk.
REQ-026 During reset outputs SHALL be M1=001, M2=001, MT=100, S=100.
REQ-027 Reset asserted mid-sequence SHALL abort the current state; after release, S1 SHALL last a full T_MAIN cycles counted from the first rising edge with rst=0.

Structure
REQ-028 State encoding (S1..S6), lamp constants (RED, YEL, GRN) and default durations SHALL live in a shared package traffic_light_pkg.
REQ-029 The block SHALL be a single module; no sub-module is required (dwell counter is inline).

Verification
REQ-030 Reset: 10 ns clk, rst pulse 10 ns -> during and right after reset M1=001, M2=001, MT=100, S=100.
REQ-031 Full sequence: after release, count edges -> S1 for 7, S2 for 2, S3 for 5, S4 for 2, S5 for 3, S6 for 2 cycles, then S1 again at edge 21.
REQ-032 Long run: 200 cycles free-running -> pattern repeats exactly every 21 cycles; every lamp output always one-hot.
REQ-033 Safety check: every cycle assert REQ-022 (e.g. in S5 light_S=001 and M1=M2=MT=100).
REQ-034 Mid-operation reset: assert rst asynchronously during S3 (between edges) -> outputs return to S1 values before next edge; S1 then lasts 7 cycles.
REQ-035 Parameter override: T_MAIN=3, T_YEL=1 -> S1 lasts 3 cycles, each yellow 1 cycle, period 3+1+5+1+3+1=14.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the four-lamp intersection controller.
// Lamp values are one-hot {red, yellow, green}.
package traffic_light_pkg;

    localparam int unsigned LAMP_W = 3;

    localparam logic [LAMP_W-1:0] RED = 3'b100;
    localparam logic [LAMP_W-1:0] YEL = 3'b010;
    localparam logic [LAMP_W-1:0] GRN = 3'b001;

    localparam int unsigned T_MAIN_DEF = 7;
    localparam int unsigned T_TURN_DEF = 5;
    localparam int unsigned T_SIDE_DEF = 3;
    localparam int unsigned T_YEL_DEF  = 2;

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_t;

    typedef struct packed {
        logic [LAMP_W-1:0] m1;
        logic [LAMP_W-1:0] m2;
        logic [LAMP_W-1:0] mt;
        logic [LAMP_W-1:0] s;
    } lamps_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Output table row for each phase; illegal encodings show all-red.
    function automatic lamps_t lamp_row(input state_t st);
        lamps_t row;
        row = '{m1: RED, m2: RED, mt: RED, s: RED};
        case (st)
            S1:      row = '{m1: GRN, m2: GRN, mt: RED, s: RED};
            S2:      row = '{m1: GRN, m2: YEL, mt: RED, s: RED};
            S3:      row = '{m1: GRN, m2: RED, mt: GRN, s: RED};
            S4:      row = '{m1: YEL, m2: RED, mt: YEL, s: RED};
            S5:      row = '{m1: RED, m2: RED, mt: RED, s: GRN};
            S6:      row = '{m1: RED, m2: RED, mt: RED, s: YEL};
            default: row = '{m1: RED, m2: RED, mt: RED, s: RED};
        endcase
        return row;
    endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Six-phase Moore controller for two main roads, a main-road turn lane and a side road.
// Each phase dwells a parameterised number of cycles; lamps decode from the state alone.
module traffic_light_controller
    import traffic_light_pkg::*;
#(
    parameter int unsigned T_MAIN = T_MAIN_DEF,
    parameter int unsigned T_TURN = T_TURN_DEF,
    parameter int unsigned T_SIDE = T_SIDE_DEF,
    parameter int unsigned T_YEL  = T_YEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LAMP_W-1:0] light_M1,
    output logic [LAMP_W-1:0] light_S,
    output logic [LAMP_W-1:0] light_MT,
    output logic [LAMP_W-1:0] light_M2
);

    localparam int unsigned T_MAX = max2(max2(T_MAIN, T_TURN), max2(T_SIDE, T_YEL));
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LAST_MAIN = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] LAST_SIDE = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           state_adv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] last_cnt;
    logic             illegal;
    lamps_t           lamps;

    // State and dwell counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Phase duration, successor, and dwell bookkeeping.
    always_comb begin
        state_nxt = S1;
        state_adv = S1;
        cnt_nxt   = '0;
        last_cnt  = '0;
        illegal   = 1'b0;

        case (state)
            S1: begin
                last_cnt  = LAST_MAIN;
                state_adv = S2;
            end
            S2: begin
                last_cnt  = LAST_YEL;
                state_adv = S3;
            end
            S3: begin
                last_cnt  = LAST_TURN;
                state_adv = S4;
            end
            S4: begin
                last_cnt  = LAST_YEL;
                state_adv = S5;
            end
            S5: begin
                last_cnt  = LAST_SIDE;
                state_adv = S6;
            end
            S6: begin
                last_cnt  = LAST_YEL;
                state_adv = S1;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal encodings keep the S1/0 defaults and so recover on the next edge.
        if (!illegal) begin
            if (cnt == last_cnt) begin
                state_nxt = state_adv;
                cnt_nxt   = '0;
            end else begin
                state_nxt = state;
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        lamps = lamp_row(state);
    end

    assign light_M1 = lamps.m1;
    assign light_M2 = lamps.m2;
    assign light_MT = lamps.mt;
    assign light_S  = lamps.s;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench: default and shortened-timing controllers checked against a
// phase-table model every cycle, plus reset, one-hot and conflict checks.
module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       rst;
    logic       rst2;
    logic [2:0] a_m1, a_s, a_mt, a_m2;
    logic [2:0] b_m1, b_s, b_mt, b_m2;

    int checks;
    int errors;

    traffic_light_controller dut_a (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (a_m1),
        .light_S  (a_s),
        .light_MT (a_mt),
        .light_M2 (a_m2)
    );

    traffic_light_controller #(
        .T_MAIN (3),
        .T_YEL  (1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst2),
        .light_M1 (b_m1),
        .light_S  (b_s),
        .light_MT (b_mt),
        .light_M2 (b_m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {m1, m2, mt, s} after p rising edges since reset release.
    function automatic logic [11:0] model(input int unsigned p, input int unsigned tm,
                                          input int unsigned tt, input int unsigned ts,
                                          input int unsigned ty);
        int unsigned r;
        r = p % (tm + tt + ts + 3 * ty);
        if (r < tm) return {G, G, R, R};
        r = r - tm;
        if (r < ty) return {G, Y, R, R};
        r = r - ty;
        if (r < tt) return {G, R, G, R};
        r = r - tt;
        if (r < ty) return {Y, R, Y, R};
        r = r - ty;
        if (r < ts) return {R, R, R, G};
        return {R, R, R, Y};
    endfunction

    function automatic logic conflict(input logic [2:0] m1, input logic [2:0] m2,
                                      input logic [2:0] mt, input logic [2:0] s);
        return ((s != R) && ((m1 != R) || (m2 != R) || (mt != R))) ||
               ((mt != R) && (m2 != R));
    endfunction

    task automatic check12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int unsigned p);
        check12({tag, "_a"}, {a_m1, a_m2, a_mt, a_s}, model(p, 7, 5, 3, 2));
        check1({tag, "_a_onehot"},
               $onehot(a_m1) && $onehot(a_m2) && $onehot(a_mt) && $onehot(a_s), 1'b1);
        check1({tag, "_a_safe"}, conflict(a_m1, a_m2, a_mt, a_s), 1'b0);
    endtask

    task automatic check_b(input string tag, input int unsigned p);
        check12({tag, "_b"}, {b_m1, b_m2, b_mt, b_s}, model(p, 3, 5, 3, 1));
        check1({tag, "_b_onehot"},
               $onehot(b_m1) && $onehot(b_m2) && $onehot(b_mt) && $onehot(b_s), 1'b1);
        check1({tag, "_b_safe"}, conflict(b_m1, b_m2, b_mt, b_s), 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rst2   = 1'b1;

        // Reset values before any clock edge.
        #2;
        check12("reset_a", {a_m1, a_m2, a_mt, a_s}, {G, G, R, R});
        check12("reset_b", {b_m1, b_m2, b_mt, b_s}, {G, G, R, R});

        // Release at t=10; first edge with rst low is at t=15.
        #8;
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        check_a("post_reset", 0);
        check_b("post_reset", 0);

        // Free run: 200 edges, expected pattern period 21 (a) and 14 (b).
        for (int p = 1; p <= 200; p++) begin
            @(posedge clk);
            #1;
            check_a("run", p);
            check_b("run", p);
        end

        // Edge 200 is offset 11 in the 21-cycle period: S3 (M1 G, MT G).
        check12("in_s3", {a_m1, a_m2, a_mt, a_s}, {G, R, G, R});

        // Asynchronous reset between edges while in S3.
        #3;
        rst = 1'b1;
        #1;
        check12("async_reset", {a_m1, a_m2, a_mt, a_s}, {G, G, R, R});
        #2;
        rst = 1'b0;
        #1;
        check_a("after_mid_reset", 0);

        for (int q = 1; q <= 30; q++) begin
            @(posedge clk);
            #1;
            check_a("mid_run", q);
            check_b("mid_run", 200 + q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
